// File: rtl/audio_pkg.sv
// Shared types and constants for the audio PWM DAC slice.
// Optional feature macro used by this slice: AUDIO_PWM_SOFT_START_EN.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dac_state_t;

    localparam int SAMPLE_W = 8;
    localparam logic [SAMPLE_W-1:0] SOFT_STEP = 8'd16;

    // Unsigned add that clamps at full scale instead of wrapping.
    function automatic logic [SAMPLE_W-1:0] sat_add(
        input logic [SAMPLE_W-1:0] a,
        input logic [SAMPLE_W-1:0] b
    );
        logic [SAMPLE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SAMPLE_W] ? {SAMPLE_W{1'b1}} : sum[SAMPLE_W-1:0];
    endfunction

    // Smaller of two unsigned sample values.
    function automatic logic [SAMPLE_W-1:0] min_u(
        input logic [SAMPLE_W-1:0] a,
        input logic [SAMPLE_W-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/audio_pwm_dac_if.sv
// Sample bus between the sound generator (master) and the PWM DAC (slave).
interface audio_pwm_dac_if;
    import audio_pkg::*;

    logic [SAMPLE_W-1:0] sample_i;
    logic                enable_i;
    logic [1:0]          vol_i;
    logic                sample_req_o;
    logic                pwm_o;
    logic                busy_o;

    modport master (
        output sample_i, enable_i, vol_i,
        input  sample_req_o, pwm_o, busy_o
    );

    modport slave (
        input  sample_i, enable_i, vol_i,
        output sample_req_o, pwm_o, busy_o
    );

endinterface

// File: rtl/pwm_frame_counter.sv
// Free-running PWM frame counter: synchronous clear, count enable,
// natural wrap at 2**CNT_BITS, and a flag on the last count of a frame.
module pwm_frame_counter #(
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    output logic [CNT_BITS-1:0] cnt,
    output logic                last
);

    // Count register: clear wins over enable, wraps to 0 after all-ones.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments for every register so all flops
        // update together from pre-edge values, independent of block order.
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == {CNT_BITS{1'b1}});

endmodule

// File: rtl/audio_pwm_dac.sv
// Audio PWM DAC: latches one unsigned sample per PWM frame, converts it to a
// 1-bit PWM stream and lets a disable finish the current frame (no clicks).
// Optional: define AUDIO_PWM_SOFT_START_EN to ramp the level up over the
// first frames after leaving IDLE.
module audio_pwm_dac
    import audio_pkg::*;
#(
    parameter int                  CNT_BITS   = 8,
    parameter logic [SAMPLE_W-1:0] MUTE_LEVEL = 8'd0
) (
    input  logic             clk,
    input  logic             rst,
    audio_pwm_dac_if.slave   bus
);

    dac_state_t          state;
    dac_state_t          state_n;
    logic                latch;
    logic                go_idle;
    logic [CNT_BITS-1:0] cnt;
    logic                cnt_last;
    logic [SAMPLE_W-1:0] duty;
    logic [SAMPLE_W-1:0] target;
    logic [SAMPLE_W-1:0] duty_load;
    logic [CNT_BITS-1:0] duty_cmp;
    logic                sample_req;

    // Zero-filled attenuation; only consumed on a latch cycle.
    assign target = bus.sample_i >> bus.vol_i;

    pwm_frame_counter #(
        .CNT_BITS (CNT_BITS)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .en   (state != IDLE),
        .cnt  (cnt),
        .last (cnt_last)
    );

`ifdef AUDIO_PWM_SOFT_START_EN
    logic [SAMPLE_W-1:0] ramp;

    assign duty_load = min_u(target, ramp);

    // Soft-start ramp: steps once per latched sample, cleared whenever idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ramp <= '0;
        end else if (latch) begin
            ramp <= sat_add(ramp, SOFT_STEP);
        end else if (go_idle || state == IDLE) begin
            ramp <= '0;
        end
    end
`else
    assign duty_load = target;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic plus the latch / mute strobes for the datapath.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and infers a latch.
        state_n = state;
        latch   = 1'b0;
        go_idle = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.enable_i) begin
                    latch   = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (cnt_last) begin
                    if (bus.enable_i) begin
                        latch = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                        state_n = IDLE;
                    end
                end else if (!bus.enable_i) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_last) begin
                    go_idle = 1'b1;
                    state_n = IDLE;
                end else if (bus.enable_i) begin
                    state_n = RUN;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Duty register and the one-cycle sample request that marks each latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty       <= MUTE_LEVEL;
            sample_req <= 1'b0;
        end else begin
            sample_req <= latch;
            if (latch) begin
                duty <= duty_load;
            end else if (go_idle) begin
                duty <= MUTE_LEVEL;
            end
        end
    end

    // Align the 8-bit duty with the counter width before comparing.
    generate
        if (CNT_BITS > SAMPLE_W) begin : g_wide
            assign duty_cmp = {{(CNT_BITS-SAMPLE_W){1'b0}}, duty};
        end else if (CNT_BITS < SAMPLE_W) begin : g_narrow
            assign duty_cmp = duty[SAMPLE_W-1 -: CNT_BITS];
        end else begin : g_equal
            assign duty_cmp = duty;
        end
    endgenerate

    // Outputs depend on registers only; no input reaches them combinationally.
    assign bus.pwm_o        = (state != IDLE) && (cnt < duty_cmp);
    assign bus.busy_o       = (state != IDLE);
    assign bus.sample_req_o = sample_req;

endmodule
